// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg
// Constants shared by the decoder, the multiply/divide unit and the D->E
// pipeline register: MD control codes, the datapath width and the
// bubble value written into the E stage when D stalls.
// Ports: none (package).
// ----------------------------------------------------------------------------
package md_pkg;

   localparam int WIDTH = 32;
   localparam int MDC_W = 4;

   typedef logic [MDC_W-1:0] mdc_t;

   localparam mdc_t MDC_MULT  = 4'b0000;
   localparam mdc_t MDC_MULTU = 4'b0001;
   localparam mdc_t MDC_DIV   = 4'b0010;
   localparam mdc_t MDC_DIVU  = 4'b0011;
   localparam mdc_t MDC_MFHI  = 4'b0100;
   localparam mdc_t MDC_MFLO  = 4'b0101;
   localparam mdc_t MDC_MTHI  = 4'b0110;
   localparam mdc_t MDC_MTLO  = 4'b0111;
   // Bubbles carry this code; it is outside 0000-0111 so it decodes to no
   // MD action and the MD read mux sees an idle selection.
   localparam mdc_t MDC_IDLE  = 4'b1000;

   localparam logic [WIDTH-1:0] BUBBLE_WORD = '0;

   // True for codes that launch an MD operation.
   function automatic logic mdc_is_start(input mdc_t code);
      return (code == MDC_MULT) || (code == MDC_MULTU) ||
             (code == MDC_DIV)  || (code == MDC_DIVU);
   endfunction

   // True for any MD instruction (codes 0000-0111).
   function automatic logic mdc_is_use(input mdc_t code);
      return (code <= MDC_MTLO);
   endfunction

endpackage

// File: rtl/md_hazard.sv
// ----------------------------------------------------------------------------
// md_hazard
// D-stage multiply/divide hazard detection plus a saturating counter of the
// cycles spent stalled on the MD unit.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   md_use         D instruction is any MD instruction
//   e_start        MD start pulse currently sitting in E
//   md_busy        busy from the MD unit
//   md_stall       combinational MD stall request
//   md_stall_cnt   saturating count of md_stall cycles
// ----------------------------------------------------------------------------
module md_hazard
   import md_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             md_use,
   input  logic             e_start,
   input  logic             md_busy,
   output logic             md_stall,
   output logic [CNT_W-1:0] md_stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // The MD unit raises busy one cycle after it sees start, so the start
   // pulse in E covers that first cycle.
   assign md_stall = md_use & (e_start | md_busy);

   always_ff @(posedge clk) begin
      if (reset) begin
         md_stall_cnt <= '0;
      end else if (md_stall && (md_stall_cnt != CNT_MAX)) begin
         md_stall_cnt <= md_stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/de_pipe_reg.sv
// ----------------------------------------------------------------------------
// de_pipe_reg
// D->E pipeline register. Carries ALU operands, MD operands/control and the
// MD start pulse into E, stalls D on data or MD hazards and inserts a bubble
// into E on every stall cycle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   D_pc .. D_imm              D-stage pc, instruction and operands
//   D_md_ctrl                  decoded MD control code
//   D_md_start                 D instruction starts an MD operation
//   D_md_use                   D instruction is any MD instruction
//   ext_stall                  stall from the data-hazard unit
//   md_busy                    busy from the MD unit
//   E_pc .. E_imm, E_md_ctrl   registered E-stage copies
//   E_start                    registered MD start pulse
//   stall_D                    combinational; freezes PC and F/D register
//   md_stall_cnt               saturating count of MD stall cycles
// ----------------------------------------------------------------------------
module de_pipe_reg
   import md_pkg::*;
#(
   parameter int                    WIDTH    = md_pkg::WIDTH,
   parameter int                    MDC_W    = md_pkg::MDC_W,
   parameter logic [MDC_W-1:0]      MDC_IDLE = md_pkg::MDC_IDLE,
   parameter int                    CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] D_pc,
   input  logic [WIDTH-1:0] D_instr,
   input  logic [WIDTH-1:0] D_rs_data,
   input  logic [WIDTH-1:0] D_rt_data,
   input  logic [WIDTH-1:0] D_imm,
   input  logic [MDC_W-1:0] D_md_ctrl,
   input  logic             D_md_start,
   input  logic             D_md_use,
   input  logic             ext_stall,
   input  logic             md_busy,
   output logic [WIDTH-1:0] E_pc,
   output logic [WIDTH-1:0] E_instr,
   output logic [WIDTH-1:0] E_rs_data,
   output logic [WIDTH-1:0] E_rt_data,
   output logic [WIDTH-1:0] E_imm,
   output logic [MDC_W-1:0] E_md_ctrl,
   output logic             E_start,
   output logic             stall_D,
   output logic [CNT_W-1:0] md_stall_cnt
);

   localparam logic [WIDTH-1:0] BUBBLE = '0;

   logic md_stall;

   md_hazard #(
      .CNT_W (CNT_W)
   ) u_md_hazard (
      .clk          (clk),
      .reset        (reset),
      .md_use       (D_md_use),
      .e_start      (E_start),
      .md_busy      (md_busy),
      .md_stall     (md_stall),
      .md_stall_cnt (md_stall_cnt)
   );

   assign stall_D = ext_stall | md_stall;

   // Reset and bubble load the same values; reset takes precedence simply
   // because it is checked first. E_start is only ever set from an accepted
   // D instruction, so a second MD op in D (which stalls on E_start) can
   // never produce back-to-back start pulses.
   always_ff @(posedge clk) begin
      if (reset || stall_D) begin
         E_pc      <= BUBBLE;
         E_instr   <= BUBBLE;
         E_rs_data <= BUBBLE;
         E_rt_data <= BUBBLE;
         E_imm     <= BUBBLE;
         E_md_ctrl <= MDC_IDLE;
         E_start   <= 1'b0;
      end else begin
         E_pc      <= D_pc;
         E_instr   <= D_instr;
         E_rs_data <= D_rs_data;
         E_rt_data <= D_rt_data;
         E_imm     <= D_imm;
         E_md_ctrl <= D_md_ctrl;
         E_start   <= D_md_start;
      end
   end

endmodule
